// File: rtl/ones_comp_pkg.sv
// ones_comp_pkg: shared width default, FSM state encoding and op codes for the ones' complement arbiter.
package ones_comp_pkg;
  localparam int WIDTH_DEF = 4;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/ones_comp_alu.sv
// ones_comp_alu: combinational ones' complement add/subtract with end-around carry.
// Subtract is only built when ONES_COMP_ARB_SUB_EN is defined; otherwise op is ignored.
module ones_comp_alu
  import ones_comp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             op,
  output logic [WIDTH-1:0] sum
);
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   raw;
`ifdef ONES_COMP_ARB_SUB_EN
  assign b_eff = (op == OP_SUB) ? ~b : b;
`else
  logic unused_op;
  assign unused_op = op;
  assign b_eff = b;
`endif
  assign raw = {1'b0, a} + {1'b0, b_eff};
  // Carry folded back into the LSB can never ripple out again.
  assign sum = raw[WIDTH-1:0] + WIDTH'(raw[WIDTH]);
endmodule

// File: rtl/ones_comp_arbiter.sv
// ones_comp_arbiter: round-robin two-requester front end for a shared ones' complement ALU.
// Subtract support is enabled by defining ONES_COMP_ARB_SUB_EN.
module ones_comp_arbiter
  import ones_comp_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_negzero
);
  state_t           state;
  logic             ptr, gnt, idle, id_q, op_q;
  logic [WIDTH-1:0] a_q, b_q, sum;
  assign idle       = rst_n && state == IDLE;
  assign gnt        = (req0_valid && req1_valid) ? ptr : req1_valid;
  assign req0_ready = idle && req0_valid && !gnt;
  assign req1_ready = idle && req1_valid && gnt;
  ones_comp_alu #(.WIDTH(WIDTH)) u_alu (.a(a_q), .b(b_q), .op(op_q), .sum(sum));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      ptr         <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= OP_ADD;
      id_q        <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_sum     <= '0;
      rsp_negzero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req0_valid || req1_valid) begin
          a_q   <= gnt ? req1_a : req0_a;
          b_q   <= gnt ? req1_b : req0_b;
          op_q  <= gnt ? req1_op : req0_op;
          id_q  <= gnt;
          ptr   <= !gnt;
          state <= EXEC;
        end
        EXEC: begin
          rsp_sum     <= sum;
          rsp_negzero <= &sum;
          rsp_id      <= id_q;
          rsp_valid   <= 1'b1;
          state       <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ones_comp_arbiter.sv
// tb_ones_comp_arbiter: directed and random transactions checked against an arithmetic model
// of ones' complement math and round-robin arbitration (subtract honoured only with ONES_COMP_ARB_SUB_EN).
module tb_ones_comp_arbiter;
  logic       clk = 1'b0, rst_n = 1'b0;
  logic       req0_valid = 0, req1_valid = 0, req0_op = 0, req1_op = 0, rsp_ready = 0;
  logic [3:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic       req0_ready, req1_ready, rsp_valid, rsp_id, rsp_negzero;
  logic [3:0] rsp_sum;
  int         vectors = 0, errs = 0;
  logic       m_ptr = 0;
  bit         sub_en;

  always #5 clk = ~clk;

  ones_comp_arbiter #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_negzero(rsp_negzero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Ones' complement value arithmetic: a sum of 16 or more wraps by subtracting 15.
  function automatic int model(input int a, input int b, input bit op);
    int r;
    r = a + ((op && sub_en) ? 15 - b : b);
    return r > 15 ? r - 15 : r;
  endfunction

  task automatic run(input bit v0, input bit v1, input int a0, input int b0, input bit o0,
                     input int a1, input int b1, input bit o1, input int stall);
    bit g;
    int e;
    @(negedge clk);
    req0_valid = v0; req0_a = 4'(a0); req0_b = 4'(b0); req0_op = o0;
    req1_valid = v1; req1_a = 4'(a1); req1_b = 4'(b1); req1_op = o1;
    rsp_ready = 0;
    #1;
    g = (v0 && v1) ? m_ptr : v1;
    e = g ? model(a1, b1, o1) : model(a0, b0, o0);
    chk("ready0_idle", req0_ready, v0 && !g);
    chk("ready1_idle", req1_ready, v1 && g);
    if (v0 || v1) m_ptr = !g;
    @(negedge clk);
    chk("ready_exec", {req0_ready, req1_ready}, 0);
    chk("valid_exec", rsp_valid, 0);
    @(negedge clk);
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_sum", rsp_sum, e);
    chk("rsp_id", rsp_id, g);
    chk("rsp_negzero", rsp_negzero, e == 15);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_sum", rsp_sum, e);
      chk("stall_id", rsp_id, g);
      chk("stall_ready", {req0_ready, req1_ready}, 0);
    end
    rsp_ready = 1;
    req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    rsp_ready = 0;
    chk("valid_done", rsp_valid, 0);
  endtask

  initial begin
`ifdef ONES_COMP_ARB_SUB_EN
    sub_en = 1;
`else
    sub_en = 0;
`endif
    req0_valid = 1; req1_valid = 1;
    #12;
    chk("rst_ready", {req0_ready, req1_ready}, 0);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_sum", rsp_sum, 0);
    chk("rst_id_nz", {rsp_id, rsp_negzero}, 0);
    req0_valid = 0; req1_valid = 0;
    @(negedge clk); rst_n = 1;
    // req0 add 3+5 = 8
    run(1, 0, 3, 5, 0, 0, 0, 0, 0);
    // subtract cases (adds when the macro is off)
    run(0, 1, 0, 0, 0, 6, 2, 1, 0);
    run(0, 1, 0, 0, 0, 5, 5, 1, 0);
    run(1, 0, 6, 2, 1, 0, 0, 0, 0);
    // end-around carry and negative zero via add
    run(1, 0, 15, 15, 0, 0, 0, 0, 0);
    run(1, 0, 9, 6, 0, 0, 0, 0, 0);
    // held back-pressure
    run(1, 1, 1, 2, 0, 4, 4, 0, 5);
    // reset mid-transaction, pointer returns to requester 0
    rst_n = 0; @(negedge clk); rst_n = 1;
    m_ptr = 0;
    for (int k = 0; k < 4; k++) run(1, 1, k, 1, 0, 8, k, 0, 0);
    @(negedge clk);
    req0_valid = 1; req0_a = 4'd7; req0_b = 4'd7;
    @(negedge clk);
    req0_valid = 0;
    #1;
    rst_n = 0;
    #1;
    chk("rstx_valid", rsp_valid, 0);
    chk("rstx_sum", rsp_sum, 0);
    chk("rstx_id_nz", {rsp_id, rsp_negzero}, 0);
    @(negedge clk); rst_n = 1;
    m_ptr = 0;
    repeat (4) begin
      @(negedge clk);
      chk("rstx_no_rsp", rsp_valid, 0);
    end
    for (int k = 0; k < 24; k++) begin
      bit v0, v1;
      v0 = 1'($urandom);
      v1 = v0 ? 1'($urandom) : 1'b1;
      run(v0, v1, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom),
          int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom), int'($urandom_range(0, 2)));
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/ones_comp_arbiter.md
ONES_COMP_ARBITER -- requirements
Module: ones_comp_arbiter

Interface
REQ-001 Parameter WIDTH, default 4: operand and result width in bits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  WIDTH  requester 0 operands.
REQ-007 req0_op  input  1  requester 0 op: 0 = add, 1 = subtract (a - b).
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op  same widths/meanings for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes result.
REQ-011 rsp_id  output  1  index of requester that owns the result.
REQ-012 rsp_sum  output  WIDTH  ones' complement result.
REQ-013 rsp_negzero  output  1  rsp_sum is all ones (negative zero).

Function
REQ-014 FSM states IDLE, EXEC, RESP; reset state IDLE.
REQ-015 IDLE: if any reqN_valid, grant one requester, assert its reqN_ready combinationally that cycle, capture a/b/op/id, go EXEC; else stay IDLE.
REQ-016 Ready SHALL be asserted only in IDLE, to at most one requester, only when that requester's valid is high.
REQ-017 Arbitration round-robin: priority pointer favours requester 0 after reset; after each acceptance, the non-granted requester gets priority next.
REQ-018 Single requester valid: granted regardless of pointer.
REQ-019 EXEC: one cycle; compute result, register into rsp_sum/rsp_negzero/rsp_id, go RESP.
REQ-020 Add: a + b, carry-out of MSB added back into LSB (end-around carry), result truncated to WIDTH.
REQ-021 Subtract: a + ~b with end-around carry.
REQ-022 No normalisation of negative zero; rsp_negzero = &rsp_sum.
REQ-023 RESP: rsp_valid = 1; rsp_id/rsp_sum/rsp_negzero held stable until rsp_valid && rsp_ready, then go IDLE.
REQ-024 Latency: acceptance at cycle N -> rsp_valid at N+2; rsp_ready high continuously gives one op per 3 cycles.
REQ-025 Requests arriving in EXEC/RESP wait (ready low); valid dropped before grant loses nothing and is not captured.

Reset
REQ-026 rst_n low: state IDLE, pointer = requester 0, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_negzero=0, both ready low; takes effect immediately.
REQ-027 Reset during EXEC or RESP discards the transaction; no response is produced after reset release.

Configuration
REQ-028 Macro ONES_COMP_ARB_SUB_EN defined: reqN_op honoured per REQ-020/021.
REQ-029 Macro undefined: reqN_op ignored, every operation is an add; no subtract logic synthesised.

Structure
REQ-030 Shared package ones_comp_pkg: WIDTH default constant, FSM state enum, op encoding constants (OP_ADD=0, OP_SUB=1).
REQ-031 Arithmetic in one combinational sub-module ones_comp_alu (a, b, op -> sum), instantiated once in the arbiter.

Verification
REQ-032 req0 add a=0011 b=0101 -> req0_ready one cycle, two cycles later rsp_sum=1000, rsp_id=0, rsp_negzero=0.
REQ-033 req1 sub a=0110 b=0010 (macro on) -> rsp_sum=0100, rsp_id=1; sub a=0101 b=0101 -> rsp_sum=1111, rsp_negzero=1.
REQ-034 Both valid held high for 4 ops after reset -> grants 0,1,0,1; rsp_id sequence matches.
REQ-035 rsp_ready low 5 cycles in RESP -> rsp_valid and outputs stable, no ready to either requester until handshake.
REQ-036 rst_n pulsed low during EXEC -> all outputs reset values immediately, no rsp_valid after release without new request.
REQ-037 Macro off, req0_op=1 a=0110 b=0010 -> rsp_sum=1000 (add performed).
